fetch_stage: RTL and testbench
==============================

# fetch_stage

Fetch stage of the WISC-F24 core. Holds the program counter, issues requests to a variable-latency instruction memory, and presents one instruction at a time to decode through a valid/accept handshake. It supplies `incPC` (PC+2) downstream to execute. It consumes execute's `newPC` redirect to steer the PC on jumps and taken branches. It also stops fetching after a HALT instruction has been accepted.

## Interface
Parameters:
- `RESET_PC`, default 16'h0000: PC value loaded on reset.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `redirect`, input, 1: execute requests a PC change this cycle.
- `newPC`, input, 16: redirect target from execute.
- `imemRd`, output, 1: instruction memory read request.
- `imemAddr`, output, 16: request address, equal to the current PC.
- `imemDone`, input, 1: memory returns `imemData` this cycle.
- `imemData`, input, 16: returned instruction word.
- `instrValid`, output, 1: `instr` and `pcOut` are valid.
- `instrAccept`, input, 1: decode consumes the instruction this cycle.
- `instr`, output, 16: held instruction.
- `pcOut`, output, 16: PC of `instr`.
- `incPC`, output, 16: `pcOut` + 2, modulo 2^16.
- `halted`, output, 1: HALT accepted; fetching has stopped.
- `misalign`, output, 1: sticky flag, set when a redirect target is odd.

## Operation
- Reset values: state FETCH, pc=`RESET_PC`, instr=16'h0800 (NOP), `instrValid`=0, `halted`=0, `misalign`=0.
- States and transitions:
  - FETCH: `imemRd`=1. If `imemDone`, capture `imemData` and go to VALID; otherwise go to WAIT.
  - WAIT: `imemRd` held at 1 and `imemAddr` held stable. On `imemDone`, capture the data and go to VALID.
  - VALID: `instrValid`=1 and `imemRd`=0.
    - If `instrAccept` and instr[15:11]==5'b00000 (HALT), go to HALTED.
    - Else if `instrAccept`, set pc ← pc+2 and go to FETCH.
  - SQUASH: entered when `redirect` occurs in WAIT. Keep `imemRd`=1 until `imemDone`, discard the data, then go to FETCH.
  - HALTED: `halted`=1, `imemRd`=0, `instrValid`=0. Only reset exits this state. `redirect` is ignored.
- Redirect (any state except HALTED):
  - Set pc ← {newPC[15:1],1'b0}. If newPC[0]==1, set `misalign`.
  - From FETCH: if `imemDone` is also high, discard the data; go to FETCH. If not, go to SQUASH.
  - From WAIT: go to SQUASH.
  - From SQUASH: stay in SQUASH and overwrite the pc.
  - From VALID: drop the held instruction, `instrValid` falls next cycle, go to FETCH.
- Priority: reset > `redirect` > `instrAccept`. A redirect in the same cycle as an accepted HALT does not halt.
- `instrAccept` while `instrValid`=0 is ignored.
- Arithmetic: the PC increment is 16-bit unsigned, so 16'hFFFE + 2 = 16'h0000 with no flag. `incPC` wraps the same way.

## Timing
- Zero-wait memory (`imemDone` in the FETCH cycle): `instrValid` rises the next cycle. With `instrAccept` held at 1, throughput is one instruction per 2 cycles.
- N-wait memory: `instrValid` rises 1 cycle after the cycle in which `imemDone` is seen.
- `redirect` takes effect on the next edge: `imemAddr`=new PC in the following cycle, unless in SQUASH.
- `instr`, `pcOut` and `incPC` are stable while `instrValid`=1 and change only on leaving VALID.
- Asserting `rst_n` low mid-transaction forces reset values immediately. A late `imemDone` after reset is released is ignored in every state except FETCH/WAIT, so the memory must also be reset.
- All outputs are registered, or decoded from state plus registers. There is no combinational path from inputs to outputs.

## Structure
- Shared `wisc_pkg` header contents:
  - state encodings FETCH/WAIT/VALID/SQUASH/HALTED.
  - `OP_HALT` = 5'b00000.
  - `NOP_INSTR` = 16'h0800.
  - `RESET_PC` default.
- Sub-module: reuse the existing `cla_16` as the PC+2 incrementer, with b=16'h0002, c_in=0, sign=0. Its output drives both `incPC` and the next-pc mux.

## Test plan
- Reset, zero-wait memory, `instrAccept`=1: `imemAddr` sequence 0x0000, 0x0002, 0x0004. `instrValid` pulses every 2nd cycle and `incPC`=`pcOut`+2.
- Memory with 3 wait cycles: `imemRd` and `imemAddr` held for 4 cycles, `instrValid` rises 1 cycle after `imemDone`, and `instr` equals the returned word.
- `redirect`=1 with `newPC`=0x0040 during WAIT: the in-flight data is discarded on `imemDone`, the next request is 0x0040, and `instr` never shows the squashed word.
- `redirect` with `newPC`=0x0031 during VALID: `instrValid` drops, the next `imemAddr`=0x0030, and `misalign`=1 and stays 1.
- HALT word 16'h0000 accepted: `halted`=1 from the next cycle, `imemRd` stays 0 for 20 cycles despite `redirect` pulses, and `rst_n` low clears it.
- PC wrap: `RESET_PC`=16'hFFFE with two accepts gives `imemAddr` 0xFFFE then 0x0000, with `incPC`=0x0000 while `pcOut`=0xFFFE.

Source files
------------

// File: rtl/wisc_pkg.sv
// Shared definitions for the WISC-F24 core: fetch FSM states, opcodes and reset constants.
package wisc_pkg;

  typedef enum logic [2:0] {
    FETCH,
    WAIT,
    VALID,
    SQUASH,
    HALTED
  } fetch_state_t;

  localparam logic [4:0]  OP_HALT          = 5'b00000;
  localparam logic [15:0] NOP_INSTR        = 16'h0800;
  localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;

  function automatic logic is_halt(input logic [15:0] word);
    return word[15:11] == OP_HALT;
  endfunction

endpackage

// File: rtl/cla_16.sv
// 16-bit carry-lookahead adder built from four 4-bit groups with group-level lookahead.
module cla_16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        c_in,
  input  logic        sign,
  output logic [15:0] sum,
  output logic        c_out,
  output logic        ovfl
);

  logic [15:0] g;
  logic [15:0] p;
  logic [3:0]  grp_g;
  logic [3:0]  grp_p;
  logic [4:0]  grp_c;
  logic [16:0] c;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    grp_g = '0;
    grp_p = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      grp_p[i] = &p[4*i +: 4];
      grp_g[i] = g[4*i+3]
               | (p[4*i+3] & g[4*i+2])
               | (p[4*i+3] & p[4*i+2] & g[4*i+1])
               | (p[4*i+3] & p[4*i+2] & p[4*i+1] & g[4*i]);
    end
  end

  always_comb begin
    grp_c    = '0;
    grp_c[0] = c_in;
    for (int unsigned i = 0; i < 4; i++) begin
      grp_c[i+1] = grp_g[i] | (grp_p[i] & grp_c[i]);
    end
  end

  // Group carries come from the lookahead; only the bits inside a group ripple.
  always_comb begin
    c = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      c[4*i] = grp_c[i];
      for (int unsigned j = 0; j < 3; j++) begin
        c[4*i+j+1] = g[4*i+j] | (p[4*i+j] & c[4*i+j]);
      end
    end
    c[16] = grp_c[4];
  end

  assign sum   = p ^ c[15:0];
  assign c_out = c[16];
  assign ovfl  = sign ? (c[16] ^ c[15]) : c[16];

endmodule

// File: rtl/fetch_stage.sv
// WISC-F24 fetch stage: PC register, variable-latency imem requests, valid/accept to decode,
// execute redirects and HALT stop.
module fetch_stage
  import wisc_pkg::*;
#(
  parameter logic [15:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect,
  input  logic [15:0] newPC,
  output logic        imemRd,
  output logic [15:0] imemAddr,
  input  logic        imemDone,
  input  logic [15:0] imemData,
  output logic        instrValid,
  input  logic        instrAccept,
  output logic [15:0] instr,
  output logic [15:0] pcOut,
  output logic [15:0] incPC,
  output logic        halted,
  output logic        misalign
);

  fetch_state_t state, next_state;
  logic [15:0]  pc, pc_next;
  logic [15:0]  instr_q, instr_next;
  logic         mis_q, mis_next;
  logic [15:0]  pc_inc;
  logic         unused_carry;
  logic         unused_ovfl;

  cla_16 u_pc_inc (
    .a     (pc),
    .b     (16'h0002),
    .c_in  (1'b0),
    .sign  (1'b0),
    .sum   (pc_inc),
    .c_out (unused_carry),
    .ovfl  (unused_ovfl)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= FETCH;
      pc      <= RESET_PC;
      instr_q <= NOP_INSTR;
      mis_q   <= 1'b0;
    end else begin
      state   <= next_state;
      pc      <= pc_next;
      instr_q <= instr_next;
      mis_q   <= mis_next;
    end
  end

  // A redirect leaves the memory with an outstanding request unless it completed this cycle
  // in FETCH, so every other fetching state drains through SQUASH.
  always_comb begin
    next_state = state;
    pc_next    = pc;
    instr_next = instr_q;
    mis_next   = mis_q;
    if (state != HALTED && redirect) begin
      pc_next = {newPC[15:1], 1'b0};
      if (newPC[0]) mis_next = 1'b1;
      case (state)
        FETCH:   next_state = imemDone ? FETCH : SQUASH;
        VALID:   next_state = FETCH;
        default: next_state = SQUASH;
      endcase
    end else begin
      case (state)
        FETCH: begin
          if (imemDone) begin
            instr_next = imemData;
            next_state = VALID;
          end else begin
            next_state = WAIT;
          end
        end
        WAIT: begin
          if (imemDone) begin
            instr_next = imemData;
            next_state = VALID;
          end
        end
        VALID: begin
          if (instrAccept) begin
            if (is_halt(instr_q)) begin
              next_state = HALTED;
            end else begin
              pc_next    = pc_inc;
              next_state = FETCH;
            end
          end
        end
        SQUASH: begin
          if (imemDone) next_state = FETCH;
        end
        HALTED:  next_state = HALTED;
        default: next_state = FETCH;
      endcase
    end
  end

  assign imemRd     = (state == FETCH) || (state == WAIT) || (state == SQUASH);
  assign imemAddr   = pc;
  assign instrValid = (state == VALID);
  assign halted     = (state == HALTED);
  assign instr      = instr_q;
  assign pcOut      = pc;
  assign incPC      = pc_inc;
  assign misalign   = mis_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized memory latency,
// accepts, redirects, HALTs and resets against a behavioural model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] newPC = '0;
  logic        imemRd;
  logic [15:0] imemAddr;
  logic        imemDone = 1'b0;
  logic [15:0] imemData = '0;
  logic        instrValid;
  logic        instrAccept = 1'b0;
  logic [15:0] instr, pcOut, incPC;
  logic        halted, misalign;

  logic        rd2, valid2, halted2, mis2;
  logic [15:0] addr2, instr2, pc2, inc2;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .redirect(redirect), .newPC(newPC),
    .imemRd(imemRd), .imemAddr(imemAddr), .imemDone(imemDone), .imemData(imemData),
    .instrValid(instrValid), .instrAccept(instrAccept), .instr(instr), .pcOut(pcOut),
    .incPC(incPC), .halted(halted), .misalign(misalign)
  );

  // Second instance: zero-wait memory returning NOPs, always accepting, reset PC at the top of memory.
  fetch_stage #(.RESET_PC(16'hFFFE)) dut2 (
    .clk(clk), .rst_n(rst_n), .redirect(1'b0), .newPC(16'h0000),
    .imemRd(rd2), .imemAddr(addr2), .imemDone(rd2), .imemData(16'h0800),
    .instrValid(valid2), .instrAccept(1'b1), .instr(instr2), .pcOut(pc2),
    .incPC(inc2), .halted(halted2), .misalign(mis2)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: holding an instruction, draining a stale request, or fetching at m_pc.
  bit          m_halted, m_valid, m_first, m_discard, m_mis;
  logic [15:0] m_pc, m_instr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_halted  <= 1'b0;
      m_valid   <= 1'b0;
      m_first   <= 1'b1;
      m_discard <= 1'b0;
      m_mis     <= 1'b0;
      m_pc      <= 16'h0000;
      m_instr   <= 16'h0800;
    end else if (!m_halted) begin
      if (redirect) begin
        m_pc  <= newPC & 16'hFFFE;
        m_mis <= m_mis | newPC[0];
        if (m_valid) begin
          m_valid   <= 1'b0;
          m_first   <= 1'b1;
          m_discard <= 1'b0;
        end else if (m_first && !m_discard && imemDone) begin
          m_first <= 1'b1;
        end else begin
          m_discard <= 1'b1;
          m_first   <= 1'b0;
        end
      end else if (m_valid) begin
        if (instrAccept) begin
          m_valid <= 1'b0;
          if (m_instr[15:11] == 5'd0) m_halted <= 1'b1;
          else begin
            m_pc    <= m_pc + 16'd2;
            m_first <= 1'b1;
          end
        end
      end else if (imemDone) begin
        if (m_discard) begin
          m_discard <= 1'b0;
          m_first   <= 1'b1;
        end else begin
          m_valid <= 1'b1;
          m_instr <= imemData;
        end
      end else begin
        m_first <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("imemRd", imemRd, !m_halted && !m_valid);
      if (!m_halted && !m_valid) chk("imemAddr", imemAddr, m_pc);
      chk("instrValid", instrValid, m_valid);
      if (m_valid) begin
        chk("instr", instr, m_instr);
        chk("pcOut", pcOut, m_pc);
        chk("incPC", incPC, m_pc + 16'd2);
      end
      chk("halted", halted, m_halted);
      chk("misalign", misalign, m_mis);
    end
  end

  // Memory and upstream/downstream stimulus
  int          lat_fixed = 0;
  int unsigned acc_pct = 100, red_pct = 0, halt_div = 0;
  bit          spur_en = 1'b0, halt_now = 1'b0, req_active = 1'b0;
  int          cnt = 0;
  logic [15:0] last_data = '0;

  task automatic compute_inputs();
    redirect    = ($urandom_range(99) < red_pct);
    newPC       = 16'($urandom);
    instrAccept = ($urandom_range(99) < acc_pct);
    if (imemRd) begin
      if (!req_active) begin
        req_active = 1'b1;
        cnt = (lat_fixed < 0) ? int'($urandom_range(3)) : lat_fixed;
      end
      if (cnt == 0) begin
        imemDone = 1'b1;
        if (halt_now || (halt_div != 0 && $urandom_range(halt_div - 1) == 0)) begin
          imemData = {5'b00000, 11'($urandom)};
          halt_now = 1'b0;
        end else begin
          imemData = {5'($urandom_range(31, 1)), 11'($urandom)};
        end
        last_data  = imemData;
        req_active = 1'b0;
      end else begin
        imemDone = 1'b0;
        imemData = 16'($urandom);
        cnt--;
      end
    end else begin
      req_active = 1'b0;
      imemDone   = spur_en && ($urandom_range(7) == 0);
      imemData   = 16'($urandom);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    compute_inputs();
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    req_active = 1'b0;
    compute_inputs();
    chk("rst_imemRd", imemRd, 1'b1);
    chk("rst_imemAddr", imemAddr, 16'h0000);
    chk("rst_instrValid", instrValid, 1'b0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_misalign", misalign, 1'b0);
    chk("rst_instr", instr, 16'h0800);
    chk("rst_imemAddr2", addr2, 16'hFFFE);
    chk("rst_imemRd2", rd2, 1'b1);
  endtask

  int halt_cnt = 0;

  initial begin
    // Zero-wait memory, accept always
    lat_fixed = 0; acc_pct = 100; red_pct = 0;
    do_reset();
    tick();
    chk("zw_valid_k1", instrValid, 1'b1);
    chk("zw_pcOut_k1", pcOut, 16'h0000);
    chk("zw_incPC_k1", incPC, 16'h0002);
    chk("zw_instr_k1", instr, last_data);
    chk("wrap_valid2", valid2, 1'b1);
    chk("wrap_pcOut2", pc2, 16'hFFFE);
    chk("wrap_incPC2", inc2, 16'h0000);
    chk("wrap_instr2", instr2, 16'h0800);
    tick();
    chk("zw_imemAddr_k2", imemAddr, 16'h0002);
    chk("zw_valid_k2", instrValid, 1'b0);
    chk("wrap_imemAddr2", addr2, 16'h0000);
    chk("wrap_halted2", halted2, 1'b0);
    chk("wrap_mis2", mis2, 1'b0);
    tick();
    tick();
    chk("zw_imemAddr_k4", imemAddr, 16'h0004);

    // Three wait cycles, no accept until the word is held
    lat_fixed = 3; acc_pct = 0;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      chk("w3_imemRd", imemRd, 1'b1);
      chk("w3_imemAddr", imemAddr, 16'h0000);
      chk("w3_valid_low", instrValid, 1'b0);
      tick();
    end
    chk("w3_valid_k4", instrValid, 1'b1);
    chk("w3_instr_k4", instr, last_data);
    instrAccept = 1'b1;
    tick();
    chk("w3_imemAddr_k5", imemAddr, 16'h0002);

    // Redirect while waiting on memory
    tick();
    redirect = 1'b1; newPC = 16'h0040;
    tick();
    chk("sq_imemAddr_k7", imemAddr, 16'h0040);
    tick();
    tick();
    chk("sq_imemAddr_k9", imemAddr, 16'h0040);
    chk("sq_valid_k9", instrValid, 1'b0);
    repeat (4) tick();
    chk("sq_valid_k13", instrValid, 1'b1);
    chk("sq_pcOut_k13", pcOut, 16'h0040);
    chk("sq_instr_k13", instr, last_data);

    // Odd redirect while holding a valid instruction, then a HALT word
    redirect = 1'b1; newPC = 16'h0031;
    lat_fixed = 0; acc_pct = 100; halt_now = 1'b1;
    tick();
    chk("mis_valid_k14", instrValid, 1'b0);
    chk("mis_imemAddr_k14", imemAddr, 16'h0030);
    chk("mis_flag_k14", misalign, 1'b1);
    tick();
    chk("halt_instr_k15", instr, 16'h0000 | last_data);
    chk("halt_valid_k15", instrValid, 1'b1);
    tick();
    red_pct = 50; spur_en = 1'b1;
    for (int k = 0; k < 20; k++) begin
      chk("halt_imemRd", imemRd, 1'b0);
      chk("halt_flag", halted, 1'b1);
      tick();
    end
    chk("halt_mis_sticky", misalign, 1'b1);
    do_reset();

    // Randomized traffic
    lat_fixed = -1; acc_pct = 60; red_pct = 8; halt_div = 50; spur_en = 1'b1;
    for (int n = 0; n < 4000; n++) begin
      tick();
      if (m_halted) halt_cnt++;
      if (halt_cnt > 4 || $urandom_range(299) == 0) begin
        halt_cnt = 0;
        do_reset();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
